// File: rtl/seq_prio_enc_pkg.sv
// Shared types and defaults for the sequential priority encoder.
package seq_prio_enc_pkg;

  typedef enum logic {
    ENC_IDLE = 1'b0,
    ENC_EMIT = 1'b1
  } enc_state_t;

  localparam int ENC_N_DEFAULT = 8;

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: index of the highest set bit, plus
// "any bit set" and "exactly one bit set" flags.
module prio_enc_comb #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         single
);

  // Ascending scan so the highest set bit wins the final assignment.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign found  = |vec;
  assign single = found && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/seq_prio_enc.sv
// Sequential priority encoder: captures a multi-hot request and emits one
// index per handshake, highest first. SEQ_PRIO_ENC_ONEHOT_EN adds a onehot port.
//
// state    | meaning
// ENC_IDLE | nothing pending, load accepted
// ENC_EMIT | pending != 0, presenting highest pending index
module seq_prio_enc
  import seq_prio_enc_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] req,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         last,
`ifdef SEQ_PRIO_ENC_ONEHOT_EN
  output logic [N-1:0] onehot,
`endif
  output logic         zero
);

  enc_state_t   state, state_nxt;
  logic [N-1:0] pending, pending_nxt;
  logic [N-1:0] clr_mask;
  logic         zero_nxt;
  logic         found;

  prio_enc_comb #(.N(N), .W(W)) u_enc (
    .vec    (pending),
    .idx    (idx),
    .found  (found),
    .single (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ENC_IDLE;
      pending <= '0;
      zero    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      zero    <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    zero_nxt      = 1'b0;
    clr_mask      = '0;
    clr_mask[idx] = 1'b1;
    case (state)
      ENC_IDLE: begin
        if (load) begin
          if (req != '0) begin
            pending_nxt = req;
            state_nxt   = ENC_EMIT;
          end else begin
            zero_nxt = 1'b1;
          end
        end
      end
      ENC_EMIT: begin
        // load is deliberately not looked at here, including on the final handshake.
        if (out_ready) begin
          pending_nxt = pending & ~clr_mask;
          if (last || !found) state_nxt = ENC_IDLE;
        end
      end
      default: begin
        state_nxt   = ENC_IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  assign out_valid = (state == ENC_EMIT);
  assign busy      = out_valid;

`ifdef SEQ_PRIO_ENC_ONEHOT_EN
  assign onehot = out_valid ? clr_mask : '0;
`endif

endmodule

// File: tb/tb_seq_prio_enc.sv
// Directed self-checking bench for seq_prio_enc (N=8); onehot checks
// are compiled in when SEQ_PRIO_ENC_ONEHOT_EN is defined.
module tb_seq_prio_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] req = '0;
  logic       out_ready = 1'b0;
  logic       busy, out_valid, last, zero;
  logic [2:0] idx;
`ifdef SEQ_PRIO_ENC_ONEHOT_EN
  logic [7:0] onehot;
`endif

  int checks = 0;
  int errors = 0;

  seq_prio_enc #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .req       (req),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .last      (last),
`ifdef SEQ_PRIO_ENC_ONEHOT_EN
    .onehot    (onehot),
`endif
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_idx"},   32'(idx), 0);
    check({tag, "_last"},  32'(last), 0);
    check({tag, "_zero"},  32'(zero), 0);
  endtask

  task automatic check_emit(input string tag, input int exp_idx, input int exp_last);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_busy"},  32'(busy), 1);
    check({tag, "_idx"},   32'(idx), 32'(exp_idx));
    check({tag, "_last"},  32'(last), 32'(exp_last));
  endtask

  initial begin
    // Reset for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_idle("reset");

    // A5: 7,5,2,0 back to back; a load on the final handshake is ignored.
    load = 1'b1; req = 8'b1010_0101; out_ready = 1'b1;
    tick();
    load = 1'b0;
    check_emit("a5_0", 7, 0);
    tick();
    check_emit("a5_1", 5, 0);
    tick();
    check_emit("a5_2", 2, 0);
    tick();
    check_emit("a5_3", 0, 1);
    load = 1'b1; req = 8'hFF;
    tick();
    load = 1'b0;
    check_idle("a5_done");
    tick();
    check_idle("a5_bubble");

    // Zero request pulses zero for one cycle.
    load = 1'b1; req = 8'h00;
    tick();
    load = 1'b0;
    check("zero_pulse", 32'(zero), 1);
    check("zero_valid", 32'(out_valid), 0);
    check("zero_busy",  32'(busy), 0);
    tick();
    check_idle("zero_after");

    // Single bit held under backpressure; FF load during hold ignored.
    load = 1'b1; req = 8'b0100_0000; out_ready = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_emit("hold", 6, 1);
      load = (i == 2);
      req  = (i == 2) ? 8'hFF : 8'h00;
      tick();
    end
    load = 1'b0;
    check_emit("hold_6th", 6, 1);
    out_ready = 1'b1;
    tick();
    check_idle("hold_done");

    // Reset mid-emit after idx=5 is accepted.
    load = 1'b1; req = 8'hFF;
    tick();
    load = 1'b0;
    check_emit("ff_0", 7, 0);
    tick();
    check_emit("ff_1", 6, 0);
    tick();
    check_emit("ff_2", 5, 0);
    tick();
    check_emit("ff_3", 4, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst");
    load = 1'b1; req = 8'b0000_0010;
    tick();
    load = 1'b0;
    check_emit("post_rst", 1, 1);
    tick();
    check_idle("post_rst_done");

`ifdef SEQ_PRIO_ENC_ONEHOT_EN
    check("oh_idle", 32'(onehot), 0);
    load = 1'b1; req = 8'b0001_1000;
    tick();
    load = 1'b0;
    check("oh_0", 32'(onehot), 32'h10);
    tick();
    check("oh_1", 32'(onehot), 32'h08);
    tick();
    check("oh_done", 32'(onehot), 0);
    check("oh_done_valid", 32'(out_valid), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
